// File: rtl/led_status_indicator_if.sv
// Control/status bundle for led_status_indicator: per-channel mode, blink rate,
// activity strobes and the registered LED drive.
interface led_status_indicator_if #(
    parameter int unsigned NUM_CH = 4
);
    logic [2*NUM_CH-1:0] mode;
    logic [2*NUM_CH-1:0] rate_sel;
    logic [NUM_CH-1:0]   evt;
    logic [NUM_CH-1:0]   led;

    modport master (
        output mode,
        output rate_sel,
        output evt,
        input  led
    );

    modport slave (
        input  mode,
        input  rate_sel,
        input  evt,
        output led
    );
endinterface

// File: rtl/led_status_indicator.sv
// Multi-channel LED status driver: OFF / ON / BLINK (4 rates) / ACTIVITY per channel.
// All channels share one free-running divider so same-rate blinkers stay in phase.
// Optional build macro CLK_IND_ACTIVE_LOW_EN inverts the LED drive and its reset value.
module led_status_indicator #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned DIVISOR_WIDTH = 24,
    parameter int unsigned TICK_BITS     = 20,
    parameter int unsigned STRETCH_TICKS = 3
) (
    input logic                   clk,
    input logic                   reset,
    led_status_indicator_if.slave bus
);
    localparam int unsigned SC_W = $clog2(STRETCH_TICKS + 1);
    localparam logic [SC_W-1:0] SC_RELOAD = SC_W'(STRETCH_TICKS);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_ACT   = 2'd3;

`ifdef CLK_IND_ACTIVE_LOW_EN
    localparam logic [NUM_CH-1:0] LED_INV = '1;
`else
    localparam logic [NUM_CH-1:0] LED_INV = '0;
`endif

    logic [DIVISOR_WIDTH-1:0] div_cnt;
    logic                     tick;
    logic [3:0]               blink_taps;
    logic [SC_W-1:0]          sc [NUM_CH];
    logic [NUM_CH-1:0]        v;
    logic [NUM_CH-1:0]        led_q;

    // Tick fires once per 2^TICK_BITS cycles, including at divider wrap.
    assign tick = &div_cnt[TICK_BITS-1:0];

    // Top four divider bits; rate r selects bit DIVISOR_WIDTH-1-r, i.e. tap index 3-r.
    assign blink_taps = div_cnt[DIVISOR_WIDTH-1 -: 4];

    // Free-running shared divider, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Per-channel stretch counters: event reload beats a tick decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.evt[i]) begin
                    sc[i] <= SC_RELOAD;
                end else if (tick && (sc[i] != '0)) begin
                    sc[i] <= sc[i] - 1'b1;
                end
            end
        end
    end

    // Display value from current registered state and current mode/rate.
    always_comb begin
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (bus.mode[2*i +: 2])
                MODE_OFF:   v[i] = 1'b0;
                MODE_ON:    v[i] = 1'b1;
                MODE_BLINK: v[i] = blink_taps[~bus.rate_sel[2*i +: 2]];
                MODE_ACT:   v[i] = (sc[i] != '0);
                default:    v[i] = 1'b0;
            endcase
        end
    end

    // Registered LED drive, polarity fixed at build time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= LED_INV;
        end else begin
            led_q <= v ^ LED_INV;
        end
    end

    assign bus.led = led_q;
endmodule

// File: tb/tb_led_status_indicator.sv
// Scoreboard bench for led_status_indicator (NUM_CH=4, DIVISOR_WIDTH=8, TICK_BITS=4,
// STRETCH_TICKS=3). Reference model works from absolute cycle numbers since reset release.
module tb_led_status_indicator;
    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int TB  = 4;
    localparam int ST  = 3;

`ifdef CLK_IND_ACTIVE_LOW_EN
    localparam logic [3:0] INV = 4'hF;
`else
    localparam logic [3:0] INV = 4'h0;
`endif

    typedef struct {
        int         due;
        logic [3:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    led_status_indicator_if #(.NUM_CH(NCH)) bus ();

    led_status_indicator #(
        .NUM_CH(NCH),
        .DIVISOR_WIDTH(DW),
        .TICK_BITS(TB),
        .STRETCH_TICKS(ST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    exp_t mon_x;
    int   k = 0;            // model cycle number since release (div_cnt == k mod 256)
    int   last_ev[NCH];     // cycle of most recent event per channel, -1 if none
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Number of tick cycles j (j mod 16 == 15) with a < j < b.
    function automatic int ticks_between(input int a, input int b);
        return (b / (1 << TB)) - ((a + 1) / (1 << TB));
    endfunction

    // Drive one cycle of inputs and queue the LED value it must produce a cycle later.
    task automatic step(input logic [7:0] m, input logic [7:0] r, input logic [3:0] e);
        exp_t       x;
        logic [3:0] v;
        int         rr;
        bus.mode     = m;
        bus.rate_sel = r;
        bus.evt      = e;
        for (int ch = 0; ch < NCH; ch++) begin
            rr = int'(r[2*ch +: 2]);
            case (m[2*ch +: 2])
                2'd0: v[ch] = 1'b0;
                2'd1: v[ch] = 1'b1;
                2'd2: v[ch] = (((k % (1 << DW)) >> (DW - 1 - rr)) & 1) != 0;
                default: v[ch] = (last_ev[ch] >= 0) &&
                                 (ticks_between(last_ev[ch], k) < ST);
            endcase
        end
        x.due = k + 1;
        x.val = v ^ INV;
        q.push_back(x);
        for (int ch = 0; ch < NCH; ch++) begin
            if (e[ch]) last_ev[ch] = k;
        end
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic model_restart();
        q.delete();
        k = 0;
        for (int ch = 0; ch < NCH; ch++) last_ev[ch] = -1;
    endtask

    task automatic check_div_zero(input string tag);
        n_checks++;
        if (dut.div_cnt !== '0) begin
            n_fail++;
            $display("FAIL %s div_cnt got=%0h exp=0", tag, dut.div_cnt);
        end
    endtask

    task automatic check_led_now(input string tag, input logic [3:0] exp);
        n_checks++;
        if (bus.led !== exp) begin
            n_fail++;
            $display("FAIL %s led got=%b exp=%b", tag, bus.led, exp);
        end
    endtask

    // Monitor: LED is presented every cycle; compare against whatever is due now.
    always @(negedge clk) begin
        if (chk_en) begin
            while (q.size() > 0 && q[0].due <= k) begin
                mon_x = q.pop_front();
                n_checks++;
                if (bus.led !== mon_x.val) begin
                    n_fail++;
                    $display("FAIL led cycle=%0d got=%b exp=%b", mon_x.due, bus.led, mon_x.val);
                end
            end
        end
    end

    initial begin
        logic [7:0] m;
        logic [7:0] r;
        logic [3:0] e;
        bus.mode = '0;
        bus.rate_sel = '0;
        bus.evt = '0;
        model_restart();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_led_now("reset_value", INV);
        check_div_zero("reset_div");
        reset = 1'b0;
        check_div_zero("first_cycle_div");
        chk_en = 1'b1;

        // All OFF for 600 cycles with random events and rates
        for (int i = 0; i < 600; i++) begin
            step(8'h00, 8'($urandom), 4'($urandom));
        end

        // Blink ch0 r=0, ch1 r=3; ch2 activity with directed event timing; ch3 OFF
        model_restart();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 320; i++) begin
            // ch2: event at 0 and at 47 (tick while sc==1) of each 64-cycle block
            e = {1'b0, ((i % 64) == 0) || ((i % 64) == 47), 2'b00};
            step({2'd0, 2'd3, 2'd2, 2'd2}, {2'd0, 2'd0, 2'd3, 2'd0}, e);
        end
        for (int i = 0; i < 256; i++) begin
            // single isolated events so the activity LED falls
            e = {1'b0, (i % 128) == 5, 2'b00};
            step({2'd0, 2'd3, 2'd2, 2'd2}, {2'd0, 2'd0, 2'd3, 2'd0}, e);
        end

        // ch3 ON -> OFF -> BLINK on consecutive cycles
        step({2'd1, 2'd3, 2'd2, 2'd2}, {2'd0, 2'd0, 2'd3, 2'd0}, 4'h0);
        step({2'd0, 2'd3, 2'd2, 2'd2}, {2'd0, 2'd0, 2'd3, 2'd0}, 4'h0);
        step({2'd2, 2'd3, 2'd2, 2'd2}, {2'd3, 2'd0, 2'd3, 2'd0}, 4'h0);
        step({2'd1, 2'd3, 2'd2, 2'd2}, {2'd3, 2'd0, 2'd3, 2'd0}, 4'h0);

        // Randomized modes, rates and sparse events across several divider wraps
        for (int i = 0; i < 1500; i++) begin
            if ((i % 37) == 0) begin
                m = 8'($urandom);
                r = 8'($urandom);
            end else if (($urandom % 8) == 0) begin
                m[2*($urandom % 4) +: 2] = 2'($urandom);
            end
            e = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if (($urandom % 4) != 0) e = 4'h0;
            step(m, r, e);
        end

        // Asynchronous reset mid-blink: LED must clear before any clock edge
        for (int i = 0; i < 40; i++) begin
            step(8'hAA, 8'hFF, 4'h0);
        end
        @(negedge clk);
        chk_en = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_led_now("async_reset", INV);
        check_div_zero("async_reset_div");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_restart();
        check_div_zero("restart_div");
        chk_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step({2'd2, 2'd3, 2'd2, 2'd2}, {2'd1, 2'd0, 2'd3, 2'd0}, {1'b0, (i == 10), 2'b00});
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound
    initial begin
        #500000;
        $display("FAIL timeout reached got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
